// File: rtl/pdm_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_pkg : shared defaults, LFSR constants and helpers for pdm_multi        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pdm_pkg;

    localparam int unsigned c_DEF_WIDTH    = 12;
    localparam int unsigned c_DEF_CHANNELS = 2;
    localparam int unsigned c_DEF_CLK_DIV  = 1;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    typedef logic [c_DEF_WIDTH-1:0] duty_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ c_LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_multi_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_channel : one first-order PDM accumulator with registered carry output |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pdm_channel
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             dith_add_i,
    input  logic             dith_sub_i,
    output logic             pdm_o
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   acc_d;

    // Dither is a signed +/-1 LSB; the subtraction wraps before the carry is taken
    assign acc_d = {1'b0, acc_q} + {1'b0, duty_i}
                 + {{WIDTH{1'b0}}, dith_add_i} - {{WIDTH{1'b0}}, dith_sub_i};

    always_ff @(posedge clk) begin
        if (rst || !enable_i) begin
            acc_q <= '0;
            pdm_o <= 1'b0;
        end else if (tick_i) begin
            acc_q <= acc_d[WIDTH-1:0];
            pdm_o <= acc_d[WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pdm_multi : multi-channel PDM modulator, double-buffered frames, prescaler |
// | Optional: define PDM_DITHER_EN for LFSR dither on the accumulators.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pdm_multi
    import pdm_pkg::*;
#(
    parameter int unsigned WIDTH    = c_DEF_WIDTH,
    parameter int unsigned CHANNELS = c_DEF_CHANNELS,
    parameter int unsigned CLK_DIV  = c_DEF_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    output logic                      underrun,
    input  logic                      underrun_clr,
    output logic [CHANNELS-1:0]       pdm_out
);

    localparam int unsigned      CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]          div_cnt_q;
    logic [CHANNELS*WIDTH-1:0] shadow_q;
    logic [CHANNELS*WIDTH-1:0] active_q;
    logic                      shadow_full_q;
    logic                      primed_q;
    logic                      underrun_q;
    logic                      tick;
    logic                      accept;
    logic                      dith_add;
    logic                      dith_sub;

    assign sample_ready = !shadow_full_q && !rst;
    assign accept       = sample_valid && sample_ready;
    assign tick         = enable && (div_cnt_q == c_DIV_LAST);
    assign underrun     = underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            primed_q      <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            if (!enable || tick) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + CNT_W'(1);
            end

            // A full shadow blocks accept, so transfer and load never collide
            if (tick && shadow_full_q) begin
                active_q      <= shadow_q;
                shadow_full_q <= 1'b0;
                primed_q      <= 1'b1;
            end
            if (accept) begin
                shadow_q      <= sample_data;
                shadow_full_q <= 1'b1;
            end

            if (tick && !shadow_full_q && primed_q) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

`ifdef PDM_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= c_LFSR_SEED;
        end else if (tick) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign dith_add = lfsr_q[0];
    assign dith_sub = lfsr_q[1];
`else
    assign dith_add = 1'b0;
    assign dith_sub = 1'b0;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        pdm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable_i   (enable),
            .tick_i     (tick),
            .duty_i     (active_q[k*WIDTH +: WIDTH]),
            .dith_add_i (dith_add),
            .dith_sub_i (dith_sub),
            .pdm_o      (pdm_out[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pdm_multi : scoreboard bench, two instances (CLK_DIV 1 and 4) on shared |
// | stimulus, checked cycle by cycle against an arithmetic model. Rev 1.0      |
// +----------------------------------------------------------------------------+
module tb_pdm_multi;

    localparam int W         = 4;
    localparam int CH        = 2;
    localparam int NI        = 2;
    localparam int FULLSCALE = 1 << W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            enable;
    logic            sample_valid;
    logic            underrun_clr;
    logic [CH*W-1:0] sample_data;
    logic            ready_o [NI];
    logic            und_o   [NI];
    logic [CH-1:0]   pdm_o   [NI];

    int n_cmp = 0;
    int n_err = 0;

    pdm_multi #(.WIDTH(W), .CHANNELS(CH), .CLK_DIV(1)) u_dut_div1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (ready_o[0]),
        .sample_data  (sample_data),
        .underrun     (und_o[0]),
        .underrun_clr (underrun_clr),
        .pdm_out      (pdm_o[0])
    );

    pdm_multi #(.WIDTH(W), .CHANNELS(CH), .CLK_DIV(4)) u_dut_div4 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (ready_o[1]),
        .sample_data  (sample_data),
        .underrun     (und_o[1]),
        .underrun_clr (underrun_clr),
        .pdm_out      (pdm_o[1])
    );

    // Reference model: duty fractions accumulated as plain integers
    typedef struct {
        logic [CH-1:0] pdm;
        logic          und;
        logic          full;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          m_div    [NI];
    int          m_acc    [NI][CH];
    int          m_sh     [NI][CH];
    int          m_act    [NI][CH];
    bit          m_full   [NI];
    bit          m_primed [NI];
    bit          m_und    [NI];
    bit [CH-1:0] m_pdm    [NI];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic model_step(input int i);
        bit   tick;
        bit   take;
        bit   set_und;
        int   s;
        exp_t e;
        if (rst) begin
            m_div[i]    = 0;
            m_full[i]   = 0;
            m_primed[i] = 0;
            m_und[i]    = 0;
            m_pdm[i]    = '0;
            for (int c = 0; c < CH; c++) begin
                m_acc[i][c] = 0;
                m_act[i][c] = 0;
                m_sh[i][c]  = 0;
            end
        end else begin
            tick    = enable && (m_div[i] == div_of(i) - 1);
            take    = sample_valid && !m_full[i];
            set_und = tick && !m_full[i] && m_primed[i];
            m_div[i] = (!enable || tick) ? 0 : m_div[i] + 1;
            for (int c = 0; c < CH; c++) begin
                if (!enable) begin
                    m_acc[i][c] = 0;
                    m_pdm[i][c] = 1'b0;
                end else if (tick) begin
                    s           = m_acc[i][c] + m_act[i][c];
                    m_pdm[i][c] = (s >= FULLSCALE);
                    m_acc[i][c] = s % FULLSCALE;
                end
            end
            if (set_und)           m_und[i] = 1;
            else if (underrun_clr) m_und[i] = 0;
            if (tick && m_full[i]) begin
                for (int c = 0; c < CH; c++) m_act[i][c] = m_sh[i][c];
                m_full[i]   = 0;
                m_primed[i] = 1;
            end
            if (take) begin
                for (int c = 0; c < CH; c++) m_sh[i][c] = int'(sample_data[c*W +: W]);
                m_full[i] = 1;
            end
        end
        e.pdm  = m_pdm[i];
        e.und  = m_und[i];
        e.full = m_full[i];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check_out(input int i, input exp_t e);
        logic er;
        er = !e.full && !rst;
        n_cmp++;
        if (pdm_o[i] !== e.pdm || und_o[i] !== e.und || ready_o[i] !== er) begin
            n_err++;
            $display("FAIL cycle_inst%0d t=%0t: got pdm=%b und=%b ready=%b, want pdm=%b und=%b ready=%b",
                     i, $time, pdm_o[i], und_o[i], ready_o[i], e.pdm, e.und, er);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) check_out(0, q0.pop_front());
        if (q1.size() > 0) check_out(1, q1.pop_front());
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [CH*W-1:0] d, input int sel);
        int guard;
        guard        = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        while (ready_o[sel] !== 1'b1 && guard < 200) begin
            cyc(1);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout inst%0d: ready stayed %b, required 1", sel, ready_o[sel]);
        end
        cyc(1);
        sample_valid = 1'b0;
    endtask

    // Ones over n cycles on the CLK_DIV=1 instance equal n*duty/2^W exactly
    task automatic check_ones(input string name, input int c, input int n, input int want);
        int ones;
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(pdm_o[0][c]);
        end
        #1;
        n_cmp++;
        if (ones != want) begin
            n_err++;
            $display("FAIL %s: counted %0d ones, required %0d", name, ones, want);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        underrun_clr = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Square wave on ch0, silence on ch1
        enable = 1'b1;
        send(8'h08, 0);
        cyc(3);
        check_ones("t1_ch0_half", 0, 32, 16);
        check_ones("t1_ch1_zero", 1, 32, 0);

        // Extreme and low densities
        send(8'h3F, 0);
        cyc(3);
        check_ones("t2_ch0_dutyF", 0, 64, 60);
        send(8'hF3, 0);
        cyc(3);
        check_ones("t2_ch0_duty3", 0, 64, 12);
        check_ones("t2_ch1_dutyF", 1, 64, 60);

        // Underrun and its clear, with and without competing ticks
        pulse_rst();
        send(8'h55, 1);
        cyc(12);
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        enable = 1'b0;
        cyc(2);
        underrun_clr = 1'b1;
        cyc(1);
        underrun_clr = 1'b0;
        cyc(2);

        // Backpressure: valid held high across back-to-back frames
        pulse_rst();
        enable = 1'b1;
        for (int f = 0; f < 6; f++) send(CH*W'($urandom), 1);
        cyc(10);

        // Reset while the shadow holds a frame
        enable = 1'b0;
        send(8'hA7, 1);
        enable = 1'b1;
        pulse_rst();
        cyc(6);

        // Enable gap mid-run restarts the accumulators
        send(8'h08, 0);
        cyc(4);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        check_ones("t6_resume_half", 0, 32, 16);

        // Randomised traffic
        for (int it = 0; it < 400; it++) begin
            int    sel;
            int unsigned r;
            r   = $urandom_range(0, 99);
            sel = int'($urandom_range(0, 1));
            if (r < 45) begin
                if (enable || ready_o[sel] === 1'b1) send(CH*W'($urandom), sel);
            end else if (r < 55) begin
                enable = ~enable;
                cyc(1);
            end else if (r < 65) begin
                underrun_clr = 1'b1;
                cyc(1);
                underrun_clr = 1'b0;
            end else if (r < 68) begin
                pulse_rst();
            end else begin
                cyc(int'($urandom_range(1, 6)));
            end
        end
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
